// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-port memory, with per-transaction timeout.
// Define MEM_ARB_RR_EN for round-robin between the ports; otherwise the data port has fixed priority.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_req_i,
  input  logic [31:0] i_addr_i,
  output logic        i_gnt_o,
  output logic        i_valid_o,
  output logic [31:0] i_rdata_o,
  output logic        i_err_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [63:0] d_addr_i,
  input  logic [63:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_valid_o,
  output logic        d_err_o,
  output logic [63:0] d_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [63:0] mem_addr_o,
  output logic [63:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [63:0] mem_rdata_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic        r_port_d;
  logic        r_we;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [63:0] r_rdata;
  logic        r_err;

  logic        w_pick_d;
  logic        w_gnt_i;
  logic        w_gnt_d;
  logic        w_timeout;
  logic        w_in_busy;
  logic        w_resp_i;
  logic        w_resp_d;

`ifdef MEM_ARB_RR_EN
  logic r_last_d;

  // Port selection: on contention, favour the port that was not served last.
  always_comb begin
    w_pick_d = 1'b0;
    if (d_req_i && i_req_i) begin
      w_pick_d = ~r_last_d;
    end else if (d_req_i) begin
      w_pick_d = 1'b1;
    end else begin
      w_pick_d = 1'b0;
    end
  end

  // Round-robin pointer: remembers which port received the most recent grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_last_d <= 1'b0;
    end else if (w_gnt_d) begin
      r_last_d <= 1'b1;
    end else if (w_gnt_i) begin
      r_last_d <= 1'b0;
    end else begin
      r_last_d <= r_last_d;
    end
  end
`else
  // Fixed priority: the data port wins whenever it requests.
  assign w_pick_d = d_req_i;
`endif

  assign w_timeout = (r_cnt == LP_CNT_LAST);

  // Next-state and grant decode; grants are held off during reset so no requester loses its grant.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_i     = 1'b0;
    w_gnt_d     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!rst_i && (i_req_i || d_req_i)) begin
          w_gnt_d     = w_pick_d;
          w_gnt_i     = ~w_pick_d;
          w_state_nxt = S_BUSY;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        if (mem_ack_i || w_timeout) begin
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_BUSY;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Transaction datapath: capture request on grant, count BUSY cycles, latch response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt    <= 8'd0;
      r_port_d <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= 64'd0;
      r_wdata  <= 64'd0;
      r_rdata  <= 64'd0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt   <= 8'd0;
          r_rdata <= 64'd0;
          r_err   <= 1'b0;
          if (w_gnt_d) begin
            r_port_d <= 1'b1;
            r_we     <= d_we_i;
            r_addr   <= d_addr_i;
            r_wdata  <= d_wdata_i;
          end else if (w_gnt_i) begin
            r_port_d <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= {32'd0, i_addr_i};
            r_wdata  <= 64'd0;
          end else begin
            r_port_d <= r_port_d;
            r_we     <= r_we;
            r_addr   <= r_addr;
            r_wdata  <= r_wdata;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt + 8'd1;
          // An ack arriving in the timeout cycle still completes normally.
          if (mem_ack_i) begin
            r_rdata <= r_we ? 64'd0 : mem_rdata_i;
            r_err   <= 1'b0;
          end else if (w_timeout) begin
            r_rdata <= 64'd0;
            r_err   <= 1'b1;
          end else begin
            r_rdata <= r_rdata;
            r_err   <= r_err;
          end
        end
        default: begin
          r_cnt   <= r_cnt;
          r_rdata <= r_rdata;
          r_err   <= r_err;
        end
      endcase
    end
  end

  assign w_in_busy = (r_state == S_BUSY);
  assign w_resp_i  = (r_state == S_RESP) && !r_port_d;
  assign w_resp_d  = (r_state == S_RESP) &&  r_port_d;

  assign i_gnt_o     = w_gnt_i;
  assign d_gnt_o     = w_gnt_d;
  assign busy_o      = (r_state != S_IDLE);

  assign mem_req_o   = w_in_busy;
  assign mem_we_o    = w_in_busy & r_we;
  assign mem_addr_o  = w_in_busy ? r_addr  : 64'd0;
  assign mem_wdata_o = w_in_busy ? r_wdata : 64'd0;

  assign i_valid_o   = w_resp_i;
  assign i_err_o     = w_resp_i & r_err;
  assign i_rdata_o   = w_resp_i ? r_rdata[31:0] : 32'd0;
  assign d_valid_o   = w_resp_d;
  assign d_err_o     = w_resp_d & r_err;
  assign d_rdata_o   = w_resp_d ? r_rdata : 64'd0;

endmodule
